// File: rtl/serial_adder_sub_pkg.sv
// =============================================================================
// Module   : serial_adder_sub_pkg
// Brief    : Shared state encoding and sizing helper for the bit-serial adder.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

package serial_adder_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width; clamped so a degenerate width still yields a legal vector.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_sub_full_adder.sv
// =============================================================================
// Module   : full_adder
// Brief    : Single-bit combinational full adder cell.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module full_adder (
  input  logic i_1,
  input  logic i_2,
  input  logic i_3,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_1 ^ i_2 ^ i_3;
  assign o_carry = (i_1 & i_2) | (i_1 & i_3) | (i_2 & i_3);

endmodule

`default_nettype wire

// File: rtl/serial_adder_sub.sv
// =============================================================================
// Module   : serial_adder_sub
// Brief    : Bit-serial adder/subtractor, one bit per clock, start/busy/done handshake.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module serial_adder_sub
  import serial_adder_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy,
  output logic             o_done
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  // Holds the WIDTH-1 partial sum bits; the final bit comes straight from the cell.
  logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
  logic               carry_q,  carry_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   sum_shift;
  logic               load;

  full_adder u_full_adder (
    .i_1     (a_sr_q[0]),
    .i_2     (b_sr_q[0]),
    .i_3     (carry_q),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  assign sum_shift = {fa_sum, sum_sr_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = i_start;
      end
      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift[WIDTH-1:1];
        carry_d  = fa_carry;
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB stage on this final step.
          sum_d   = sum_shift;
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        load    = i_start;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      a_sr_d   = i_a;
      b_sr_d   = i_sub ? ~i_b : i_b;
      carry_d  = i_sub | i_cin;
      sum_sr_d = '0;
      cnt_d    = '0;
      state_d  = ST_SHIFT;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_sum  = sum_q;
  assign o_cout = cout_q;
  assign o_ovf  = ovf_q;
  assign o_busy = (state_q == ST_SHIFT);
  assign o_done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_sub.sv
// =============================================================================
// Module   : tb_serial_adder_sub
// Brief    : Self-checking bench for serial_adder_sub (WIDTH=8).
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_serial_adder_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] o_sum;
  logic         o_cout, o_ovf, o_busy, o_done;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  serial_adder_sub #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sub   (sub),
    .i_cin   (cin),
    .i_a     (a),
    .i_b     (b),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic: {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rsub, input logic rcin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = rsub ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rsub ? 1'b1 : rcin)};
    ov   = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Transaction-level model: an accepted op becomes visible W+1 edges later.
  logic         m_busy, m_done;
  int           m_left;
  logic [W+1:0] m_pend, m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else if (start) begin
      m_pend <= ref_op(a, b, sub, cin);
      m_busy <= 1'b1;
      m_left <= W;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", {31'd0, o_busy}, {31'd0, m_busy});
      check("done", {31'd0, o_done}, {31'd0, m_done});
      check("result", {22'd0, o_ovf, o_cout, o_sum}, {22'd0, m_res});
    end
  end

  task automatic wait_done(input bit drop_start, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_start) start = 1'b0;
    end while (!o_done && n < 40);
    if (!o_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input logic tc);
    a = ta; b = tb_; sub = ts; cin = tc;
  endtask

  task automatic check_res(input string name, input logic [W-1:0] es, input logic ec,
                           input logic eo);
    check({name, "_sum"},  {24'd0, o_sum}, {24'd0, es});
    check({name, "_cout"}, {31'd0, o_cout}, {31'd0, ec});
    check({name, "_ovf"},  {31'd0, o_ovf}, {31'd0, eo});
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic tc, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int n;
    @(negedge clk);
    set_op(ta, tb_, ts, tc);
    start = 1'b1;
    wait_done(1'b1, n);
    check({name, "_latency"}, n, W + 1);
    check_res(name, es, ec, eo);
  endtask

  initial begin
    int n, n2;
    repeat (3) @(negedge clk);
    check_res("reset", 8'h00, 1'b0, 1'b0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic add with done width check
    run_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    @(negedge clk);
    check("done_width", {31'd0, o_done}, 32'd0);

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("add_cin",   8'hA0, 8'h5F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // Start pulses during SHIFT must be ignored
    @(negedge clk);
    set_op(8'h12, 8'h34, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); set_op(8'hFF, 8'hFF, 1'b1, 1'b0); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); set_op(8'hAA, 8'h55, 1'b0, 1'b1); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1'b0, n);
    check("ignore_latency", n + 6, W + 1);
    check_res("ignore", 8'h47, 1'b0, 1'b0);

    // Back-to-back: start held through DONE
    repeat (2) @(negedge clk);
    set_op(8'h10, 8'h20, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    set_op(8'h64, 8'h64, 1'b0, 1'b0);
    wait_done(1'b0, n);
    check("b2b_first_latency", n + 1, W + 1);
    check_res("b2b_first", 8'hF0, 1'b0, 1'b0);
    wait_done(1'b1, n2);
    check("b2b_spacing", n2, W + 1);
    check_res("b2b_second", 8'hC8, 1'b0, 1'b1);

    // Reset during SHIFT aborts
    @(negedge clk);
    set_op(8'h33, 8'h11, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_res("rst_mid", 8'h00, 1'b0, 1'b0);
    check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    check("rst_mid_done", {31'd0, o_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done) n2++;
    end
    check("no_done_after_rst", n2, 0);
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
